// File: rtl/bcd_time_counter.sv
// BCD HH:MM:SS time-of-day counter: cascaded BCD digits with ripple carry,
// registered carry pulses, and a set mode that bumps one field at a time.
module bcd_time_counter #(
  parameter int unsigned HR_MAX = 23,
  parameter int unsigned HR_MIN = 0
) (
  input  logic       CP,
  input  logic       CR,
  input  logic       tick,
  input  logic       set_en,
  input  logic [1:0] set_sel,
  input  logic       set_inc,
  output logic [7:0] sec,
  output logic [7:0] min,
  output logic [7:0] hour,
  output logic       co_min,
  output logic       co_hour,
  output logic       co_day
);

  localparam logic [7:0] HR_MAX_BCD = 8'(((HR_MAX / 10) << 4) | (HR_MAX % 10));
  localparam logic [7:0] HR_MIN_BCD = 8'(((HR_MIN / 10) << 4) | (HR_MIN % 10));

  logic [7:0] sec_q, sec_d, min_q, min_d, hour_q, hour_d;
  logic       co_min_q, co_min_d, co_hour_q, co_hour_d, co_day_q, co_day_d;
  logic       sec_wrap, min_wrap, hour_wrap;
  logic [7:0] sec_nx, min_nx, hour_nx;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // Each field's successor already includes its own wrap, so set mode and
  // counting share the same next values; only the carry chaining differs.
  always_comb begin
    sec_wrap  = (sec_q == 8'h59);
    min_wrap  = (min_q == 8'h59);
    hour_wrap = (hour_q == HR_MAX_BCD);
    sec_nx    = sec_wrap  ? 8'h00      : bcd_inc(sec_q);
    min_nx    = min_wrap  ? 8'h00      : bcd_inc(min_q);
    hour_nx   = hour_wrap ? HR_MIN_BCD : bcd_inc(hour_q);

    sec_d     = sec_q;
    min_d     = min_q;
    hour_d    = hour_q;
    co_min_d  = 1'b0;
    co_hour_d = 1'b0;
    co_day_d  = 1'b0;

    if (set_en) begin
      if (set_inc) begin
        case (set_sel)
          2'd0:    sec_d  = sec_nx;
          2'd1:    min_d  = min_nx;
          2'd2:    hour_d = hour_nx;
          default: ;
        endcase
      end
    end else if (tick) begin
      sec_d = sec_nx;
      if (sec_wrap) begin
        co_min_d = 1'b1;
        min_d    = min_nx;
        if (min_wrap) begin
          co_hour_d = 1'b1;
          hour_d    = hour_nx;
          co_day_d  = hour_wrap;
        end
      end
    end
  end

  always_ff @(posedge CP) begin
    if (CR) begin
      sec_q     <= 8'h00;
      min_q     <= 8'h00;
      hour_q    <= HR_MIN_BCD;
      co_min_q  <= 1'b0;
      co_hour_q <= 1'b0;
      co_day_q  <= 1'b0;
    end else begin
      sec_q     <= sec_d;
      min_q     <= min_d;
      hour_q    <= hour_d;
      co_min_q  <= co_min_d;
      co_hour_q <= co_hour_d;
      co_day_q  <= co_day_d;
    end
  end

  assign sec     = sec_q;
  assign min     = min_q;
  assign hour    = hour_q;
  assign co_min  = co_min_q;
  assign co_hour = co_hour_q;
  assign co_day  = co_day_q;

endmodule

// File: doc/bcd_time_counter.md
Name: bcd_time_counter

Overview:
- Downstream consumer of the lab's 4-bit counter stage. Turns a one-cycle count-enable pulse (the 1 Hz tick from the prescaler/161 chain) into a BCD HH:MM:SS time-of-day value.
- Built as six cascaded BCD digit counters with ripple-enable carry, like chained 161s with synchronous load.
- Outputs feed the seven-segment scan/display stage.
- Also supports manual time setting: select a field, then increment it.

Parameters:
- HR_MAX, 23, last hour value before wrap to 00. 23 gives 24-hour mode; legal range 1..23.
- HR_MIN, 0, hour value loaded on hour wrap. Set to 1 with HR_MAX=12 for 12-hour mode.

Ports:
- CP  input  1  system clock, rising-edge active
- CR  input  1  synchronous reset, active-high
- tick  input  1  count enable, one CP cycle wide, advances time by one second
- set_en  input  1  set mode: 1 = counting halted, fields editable
- set_sel  input  2  field select: 0 = sec, 1 = min, 2 = hour, 3 = none
- set_inc  input  1  one-cycle pulse: increment selected field (set mode only)
- sec  output  8  BCD seconds {tens, ones}
- min  output  8  BCD minutes {tens, ones}
- hour  output  8  BCD hours {tens, ones}
- co_min  output  1  one-cycle pulse when seconds wrap 59→00 by tick
- co_hour  output  1  one-cycle pulse when minutes wrap 59→00 by tick
- co_day  output  1  one-cycle pulse when hours wrap HR_MAX→HR_MIN by tick

Behaviour:
- All state updates on rising CP. No asynchronous paths.
- Priority per cycle: CR > set_en > tick.
- Reset (CR=1):
  - sec=8'h00, min=8'h00, hour = BCD(HR_MIN).
  - co_min, co_hour and co_day are 0.
  - Reset mid-count or mid-set takes effect the same edge.
- Counting (set_en=0, tick=1), all in the same edge:
  - sec ones 0..9; at 9 wraps to 0 and enables sec tens.
  - sec tens 0..5; at 59 wraps to 00 and enables min.
  - min behaves identically to sec. At 59 with sec=59, wraps to 00 and enables hour.
  - hour at HR_MAX (with min=59, sec=59) loads BCD(HR_MIN). Otherwise BCD increment (09→10, 19→20).
  - Full ripple resolves in one cycle: 23:59:59 + tick → 00:00:00 at the next edge.
- tick=0 with set_en=0: all fields hold.
- Carry outputs:
  - Registered, asserted in the cycle after the wrapping edge, for exactly one cycle.
  - co_min at sec 59→00, co_hour at min 59→00, co_day at hour wrap.
  - Nested wraps raise all applicable carries together. Example: 23:59:59 → co_min, co_hour and co_day all 1 for one cycle.
- Set mode (set_en=1):
  - tick is ignored; time holds and no tick-driven carries are produced.
  - set_inc=1 increments only the field chosen by set_sel, wrapping within that field with no carry to the next field:
    - sec 59→00, min 59→00, hour HR_MAX→HR_MIN.
  - Carry outputs stay 0 in set mode.
  - set_sel=3 or set_inc=0: hold.
  - Setting sec also clears nothing else; fields are independent.
- Leaving set mode:
  - A tick on the first cycle with set_en=0 counts normally.
  - A tick that arrives while set_en=1 is dropped, not queued.
- Legal values: outputs always hold valid BCD within range. No illegal-state recovery is required beyond CR.

Test Plan:
- CR=1 two cycles, then CR=0 with no tick → sec=8'h00, min=8'h00, hour=8'h00, all carries 0, and values hold for 20 cycles.
- Preset 00:00:58 via set mode, then 2 ticks → sec 8'h59 then 8'h00, min=8'h01, co_min high for exactly one cycle after the second tick.
- Preset 09:59:59, one tick → hour=8'h10, min=8'h00, sec=8'h00, co_min=co_hour=1 for one cycle, co_day=0.
- Preset 23:59:59, one tick → 00:00:00, co_min=co_hour=co_day=1 for one cycle. Repeat with HR_MAX=12, HR_MIN=1 from 12:59:59 → 01:00:00.
- set_en=1, set_sel=1, 61 set_inc pulses from min=00 → min=8'h01, hour unchanged, no carries. Ticks applied during set mode change nothing.
- Counting at 00:00:30 with tick and CR=1 on the same edge → 00:00:00. Next tick → 00:00:01.
